// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state encoding,
// opcode constants and the default drain depth.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SWAP2  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [3:0] OPC_ATYPE = 4'b0001;
    localparam logic [3:0] FUNC_SWAP = 4'b1111;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    // A swap is an A-type instruction whose function field selects the swap.
    function automatic logic is_swap(input logic [3:0] opc, input logic [3:0] func);
        return (opc == OPC_ATYPE) && (func == FUNC_SWAP);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/status inputs and pipeline control outputs of the hazard sequencer.
// The slave modport is the sequencer's view; master is the pipeline datapath's.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 4
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_jump;
    logic                  id_halt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_branch_taken;
    logic                  ex_overflow;
    logic                  wb_write_op2;

    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic wb_sel_op2;
    logic halted;
    logic ovf_error;

    modport master (
        output id_valid, id_rs1, id_rs2, id_jump, id_halt,
               ex_mem_read, ex_rd, ex_branch_taken, ex_overflow, wb_write_op2,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, wb_sel_op2, halted, ovf_error
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_jump, id_halt,
               ex_mem_read, ex_rd, ex_branch_taken, ex_overflow, wb_write_op2,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, wb_sel_op2, halted, ovf_error
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Loads into register 0 never stall.
module hazard_detect #(
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  stall_o
);

    always_comb begin
        stall_o = id_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                  ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: PC / pipeline-register enables and
// flushes for load-use stalls, branch/jump/overflow flushes, swap serialisation and halt.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = 4,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ret_q, ret_d;
    logic             ovf_q, ovf_d;
    logic             load_use;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, wb_sel_op2, halted;

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard_detect (
        .id_valid_i   (bus.id_valid),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .ex_mem_read_i(bus.ex_mem_read),
        .ex_rd_i      (bus.ex_rd),
        .stall_o      (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ret_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        ovf_d       = ovf_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        wb_sel_op2  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.wb_write_op2) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    ret_d   = 1'b0;
                    state_d = SWAP2;
                end else if (bus.ex_overflow) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    ovf_d       = 1'b1;
                    cnt_d       = CNT_INIT;
                    state_d     = DRAIN;
                end else if (bus.ex_branch_taken) begin
                    // Younger ID-stage halt/jump/load-use are on the wrong path.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.id_halt && bus.id_valid) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = DRAIN;
                end else if (bus.id_jump && bus.id_valid) begin
                    ifid_flush = 1'b1;
                end
            end

            SWAP2: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                wb_sel_op2 = 1'b1;
                state_d    = ret_q ? DRAIN : RUN;
                ret_d      = 1'b0;
            end

            DRAIN: begin
                if (bus.wb_write_op2) begin
                    // Whole-pipe hold freezes the drain count; ret_q brings us back here.
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    ret_d   = 1'b1;
                    state_d = SWAP2;
                end else begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            HALTED: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                halted = 1'b1;
            end

            default: state_d = RUN;
        endcase
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_en    = exmem_en;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_en    = memwb_en;
    assign bus.wb_sel_op2  = wb_sel_op2;
    assign bus.halted      = halted;
    assign bus.ovf_error   = ovf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// control vectors, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W  (4),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en
    //               exmem_flush memwb_en wb_sel_op2 halted ovf_error
    localparam logic [10:0] E_DEF  = 11'b11010101000;
    localparam logic [10:0] E_LU   = 11'b00011101000;
    localparam logic [10:0] E_BR   = 11'b11111101000;
    localparam logic [10:0] E_JMP  = 11'b11110101000;
    localparam logic [10:0] E_HOLD = 11'b00000000000;
    localparam logic [10:0] E_SWP  = 11'b00000000100;
    localparam logic [10:0] E_HLTI = 11'b01111101000;
    localparam logic [10:0] E_OVF  = 11'b01111111000;
    localparam logic [10:0] E_DRN  = 11'b00011101000;
    localparam logic [10:0] E_PARK = 11'b00000000010;

    typedef struct {
        string       nm;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [10:0] act;
    assign act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.wb_sel_op2,
                  bus.halted, bus.ovf_error};

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic jmp, input logic hlt, input logic mr,
                         input logic [3:0] rd, input logic br, input logic ov,
                         input logic wb);
        bus.id_valid        = v;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_jump         = jmp;
        bus.id_halt         = hlt;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
        bus.ex_overflow     = ov;
        bus.wb_write_op2    = wb;
    endtask

    task automatic step(input string nm, input logic [10:0] e,
                        input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic jmp, input logic hlt, input logic mr,
                        input logic [3:0] rd, input logic br, input logic ov,
                        input logic wb);
        exp_t x;
        @(posedge clk);
        #1;
        drive(v, rs1, rs2, jmp, hlt, mr, rd, br, ov, wb);
        x.nm = nm;
        x.v  = e;
        sb.push_back(x);
    endtask

    task automatic idle(input string nm, input logic [10:0] e);
        step(nm, e, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
    endtask

    // Asynchronous reset mid-cycle; checked before the next rising edge.
    task automatic reset_now(input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        drive(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        rst_n = 1'b0;
        x.nm = nm;
        x.v  = E_DEF;
        sb.push_back(x);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        idle("reset_state", E_DEF);
        release_rst();

        idle("idle", E_DEF);
        step("lu_rs2", E_LU, 1, 4'd5, 4'd3, 0, 0, 1, 4'd3, 0, 0, 0);
        idle("lu_one_bubble", E_DEF);
        step("lu_r0_nostall", E_DEF, 1, 4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        step("lu_invalid", E_DEF, 0, 4'd7, 4'd2, 0, 0, 1, 4'd7, 0, 0, 0);
        step("lu_rs1", E_LU, 1, 4'd9, 4'd1, 0, 0, 1, 4'd9, 0, 0, 0);
        step("no_load_match", E_DEF, 1, 4'd9, 4'd1, 0, 0, 0, 4'd9, 0, 0, 0);
        step("jump", E_JMP, 1, 4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
        step("jump_invalid", E_DEF, 0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 0, 0);
        step("br_halt_jump_lu", E_BR, 1, 4'd4, 4'd0, 1, 1, 1, 4'd4, 1, 0, 0);
        idle("after_branch_run", E_DEF);

        step("swap_hold", E_HOLD, 1, 4'd2, 4'd2, 1, 0, 1, 4'd2, 1, 1, 1);
        step("swap2_ignores_inputs", E_SWP, 1, 4'd3, 4'd3, 0, 1, 1, 4'd3, 1, 1, 0);
        idle("swap_back_to_run", E_DEF);

        step("ovf_beats_branch", E_OVF, 1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 0);
        idle("ovf_drain1", E_DRN | 11'b1);
        step("ovf_drain2_ignore", E_DRN | 11'b1, 1, 4'd0, 4'd0, 0, 1, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 22; i++) begin
            step("ovf_parked", E_PARK | 11'b1, 1, 4'd0, 4'd0, (i % 2) == 0, 1, 0, 4'd0,
                 (i % 3) == 0, (i % 2) == 1, (i % 4) == 0);
        end
        reset_now("rst_from_halted");
        release_rst();

        step("halt", E_HLTI, 1, 4'd0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);
        idle("halt_drain1", E_DRN);
        step("halt_drain2_ignore", E_DRN, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 21; i++) begin
            idle("halt_parked", E_PARK);
        end
        reset_now("rst_halted2");
        release_rst();

        step("halt_b", E_HLTI, 1, 4'd0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);
        idle("drain_b1", E_DRN);
        step("drain_swap_hold", E_HOLD, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        idle("drain_swap2", E_SWP);
        idle("drain_resume", E_DRN);
        idle("drain_b_parked", E_PARK);

        reset_now("rst_park");
        release_rst();
        step("halt_c", E_HLTI, 1, 4'd0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);
        reset_now("rst_mid_drain");
        release_rst();
        idle("run_after_drain_rst", E_DEF);
        step("swap_hold_c", E_HOLD, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1);
        reset_now("rst_mid_swap2");
        release_rst();
        idle("run_after_swap_rst", E_DEF);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
